frame_buffer_axi4_slave: RTL

FRAME_BUFFER_AXI4_SLAVE -- requirements
Module: frame_buffer_axi4_slave

---
 rtl/frame_buffer_axi4_slave.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/frame_buffer_axi4_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_buffer_axi4_slave: AXI4 write-only slave into a line buffer     |
// | with a registered consumer-side read port.      Rev 1.0               |
// +----------------------------------------------------------------------+
module frame_buffer_axi4_slave #(
   parameter int                  DATA_W       = 256,
   parameter int                  ADDR_W       = 32,
   parameter int                  MST_ID_W     = 5,
   parameter int                  TRANS_RESP_W = 2,
   parameter logic [ADDR_W-1:0]   BASE_ADDR    = 32'h8000_0000,
   parameter int                  MEM_DEPTH    = 64
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [MST_ID_W-1:0]           s_awid_i,
   input  logic [ADDR_W-1:0]             s_awaddr_i,
   input  logic                          s_awvalid_i,
   output logic                          s_awready_o,
   input  logic [DATA_W-1:0]             s_wdata_i,
   input  logic                          s_wlast_i,
   input  logic                          s_wvalid_i,
   output logic                          s_wready_o,
   output logic [MST_ID_W-1:0]           s_bid_o,
   output logic [TRANS_RESP_W-1:0]       s_bresp_o,
   output logic                          s_bvalid_o,
   input  logic                          s_bready_i,
   input  logic                          rd_en_i,
   input  logic [$clog2(MEM_DEPTH)-1:0]  rd_idx_i,
   output logic [DATA_W-1:0]             rd_data_o,
   output logic [15:0]                   beat_cnt_o
);

   localparam int                        c_idx_w   = $clog2(MEM_DEPTH);
   localparam int                        c_shift   = $clog2(DATA_W/8);
   localparam logic signed [ADDR_W:0]    c_depth   = (ADDR_W+1)'(MEM_DEPTH);
   localparam logic signed [ADDR_W:0]    c_one     = (ADDR_W+1)'(1);
   localparam logic [c_idx_w:0]          c_depth_u = (c_idx_w+1)'(MEM_DEPTH);
   localparam logic [TRANS_RESP_W-1:0]   c_okay    = TRANS_RESP_W'(0);
   localparam logic [TRANS_RESP_W-1:0]   c_slverr  = TRANS_RESP_W'(2);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                    r_state;
   logic                      r_awready;
   logic                      r_wready;
   logic                      r_bvalid;
   logic [MST_ID_W-1:0]       r_bid;
   logic [TRANS_RESP_W-1:0]   r_bresp;
   logic                      r_err;
   logic signed [ADDR_W:0]    r_idx;
   logic [15:0]               r_beat_cnt;
   logic [DATA_W-1:0]         r_rd_data;
   logic [DATA_W-1:0]         r_mem [MEM_DEPTH];

   logic signed [ADDR_W:0]    w_aw_off;
   logic signed [ADDR_W:0]    w_aw_idx;
   logic                      w_in_range;
   logic                      w_w_hs;
   logic                      w_wr;

   // Offset is taken one bit wider so addresses below BASE_ADDR go negative.
   assign w_aw_off   = $signed({1'b0, s_awaddr_i}) - $signed({1'b0, BASE_ADDR});
   assign w_aw_idx   = w_aw_off >>> c_shift;
   assign w_in_range = !r_idx[ADDR_W] && (r_idx < c_depth);
   assign w_w_hs     = r_wready && s_wvalid_i;
   assign w_wr       = w_w_hs && w_in_range;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_awready  <= 1'b0;
         r_wready   <= 1'b0;
         r_bvalid   <= 1'b0;
         r_bid      <= '0;
         r_bresp    <= '0;
         r_err      <= 1'b0;
         r_idx      <= '0;
         r_beat_cnt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_awready <= 1'b1;
               if (s_awvalid_i && r_awready) begin
                  r_bid     <= s_awid_i;
                  r_idx     <= w_aw_idx;
                  r_err     <= 1'b0;
                  r_awready <= 1'b0;
                  r_wready  <= 1'b1;
                  r_state   <= DATA;
               end
            end
            DATA: begin
               if (w_w_hs) begin
                  r_idx <= r_idx + c_one;
                  if (w_in_range) begin
                     r_beat_cnt <= r_beat_cnt + 16'd1;
                  end else begin
                     r_err <= 1'b1;
                  end
                  if (s_wlast_i) begin
                     // Fold in the last beat's own range error, not yet in r_err.
                     r_bresp  <= (r_err || !w_in_range) ? c_slverr : c_okay;
                     r_wready <= 1'b0;
                     r_bvalid <= 1'b1;
                     r_state  <= RESP;
                  end
               end
            end
            RESP: begin
               if (s_bready_i) begin
                  r_bvalid  <= 1'b0;
                  r_awready <= 1'b1;
                  r_state   <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_idx[c_idx_w-1:0]] <= s_wdata_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_data <= '0;
      end else if (rd_en_i) begin
         r_rd_data <= ({1'b0, rd_idx_i} < c_depth_u) ? r_mem[rd_idx_i] : '0;
      end
   end

   assign s_awready_o = r_awready;
   assign s_wready_o  = r_wready;
   assign s_bvalid_o  = r_bvalid;
   assign s_bid_o     = r_bid;
   assign s_bresp_o   = r_bresp;
   assign rd_data_o   = r_rd_data;
   assign beat_cnt_o  = r_beat_cnt;

endmodule
`default_nettype wire
